// File: rtl/osc_period_counter_pkg.sv
// Shared types and constants for the oscillator period measurement block.
//   state_t  : measurement FSM encoding (IDLE / ARM / MEASURE)
//   COUNT_W  : width of the cycle count and timeout counter
//   CNT_SAT  : saturation value of the cycle counter
//   PER_W    : width of the oscillator period counter
//   sat_inc  : increment that sticks at CNT_SAT instead of wrapping
package osc_meas_pkg;

   localparam int COUNT_W = 32;
   localparam logic [COUNT_W-1:0] CNT_SAT = 32'hFFFF_FFFF;
   localparam int PER_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
      return (value == CNT_SAT) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/osc_period_counter_if.sv
// Result/control bundle of the period counter.
//   enable      : level, high = measure continuously (consumer -> counter)
//   count_out   : clk cycles spanned by the last N_PERIODS oscillator periods
//   count_valid : one-cycle pulse, count_out carries a new value
//   timeout     : one-cycle pulse, measurement aborted for lack of edges
//   busy        : high while the counter is in ARM or MEASURE
// master = the period counter, slave = the downstream consumer.
interface osc_period_counter_if;
   import osc_meas_pkg::*;

   logic               enable;
   logic [COUNT_W-1:0] count_out;
   logic               count_valid;
   logic               timeout;
   logic               busy;

   modport master (
      input  enable,
      output count_out,
      output count_valid,
      output timeout,
      output busy
   );

   modport slave (
      output enable,
      input  count_out,
      input  count_valid,
      input  timeout,
      input  busy
   );

endinterface

// File: rtl/osc_period_counter_sync.sv
// Synchronizer plus rising-edge detector for a single asynchronous input.
// Latency from an input rise to rise_pulse is SYNC_STAGES + 1 clk cycles.
//   clk        : sampling clock
//   reset      : synchronous, active-high; clears every flop
//   async_in   : asynchronous input
//   rise_pulse : registered one-cycle pulse per synchronized rising edge
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise_pulse
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [SYNC_STAGES-1:0] sync_next;
   logic                   hist_reg;
   logic                   rise_reg;

   genvar gi;
   generate
      for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign sync_next[gi] = async_in;
         end else begin : g_rest
            assign sync_next[gi] = sync_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg <= '0;
         hist_reg <= 1'b0;
         rise_reg <= 1'b0;
      end else begin
         sync_reg <= sync_next;
         // History flop holds the previous synchronized level for edge compare.
         hist_reg <= sync_reg[SYNC_STAGES-1];
         rise_reg <= sync_reg[SYNC_STAGES-1] & ~hist_reg;
      end
   end

   assign rise_pulse = rise_reg;

endmodule

// File: rtl/osc_period_counter.sv
// Oscillator period counter: counts clk cycles across N_PERIODS rising edges
// of an asynchronous oscillator and publishes one 32-bit count per
// measurement. Consecutive measurements share their boundary edge, so there
// is no dead time while enable stays high.
//   clk    : system clock
//   reset  : synchronous, active-high
//   osc_in : asynchronous oscillator input
//   meas   : master side of osc_period_counter_if
//            (enable in; count_out, count_valid, timeout, busy out)
module osc_period_counter
   import osc_meas_pkg::*;
#(
   parameter int          N_PERIODS      = 16,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000,
   parameter int          SYNC_STAGES    = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic osc_in,
   osc_period_counter_if.master meas
);

   localparam logic [PER_W-1:0]   LAST_PER = PER_W'(N_PERIODS - 1);
   localparam logic [COUNT_W-1:0] TMO_LAST = TIMEOUT_CYCLES - 32'd1;

   logic edge_pulse;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk        (clk),
      .reset      (reset),
      .async_in   (osc_in),
      .rise_pulse (edge_pulse)
   );

   state_t             state_reg, state_next;
   logic [COUNT_W-1:0] cyc_reg, cyc_next;
   logic [PER_W-1:0]   per_reg, per_next;
   logic [COUNT_W-1:0] tmo_reg, tmo_next;
   logic [COUNT_W-1:0] count_reg, count_next;
   logic               valid_reg, valid_next;
   logic               timeout_reg, timeout_next;
   logic               busy_reg, busy_next;
   logic               completing;

   // The edge that brings per_cnt up to N_PERIODS closes the measurement.
   assign completing = (state_reg == MEASURE) && edge_pulse && (per_reg == LAST_PER);

   always_comb begin
      state_next   = state_reg;
      cyc_next     = cyc_reg;
      per_next     = per_reg;
      tmo_next     = tmo_reg;
      count_next   = count_reg;
      valid_next   = 1'b0;
      timeout_next = 1'b0;

      case (state_reg)
         IDLE: begin
            cyc_next = '0;
            per_next = '0;
            tmo_next = '0;
            if (meas.enable) begin
               state_next = ARM;
            end
         end

         ARM: begin
            if (!meas.enable) begin
               state_next = IDLE;
               tmo_next   = '0;
            end else if (edge_pulse) begin
               cyc_next   = '0;
               per_next   = '0;
               tmo_next   = '0;
               state_next = MEASURE;
            end else if (tmo_reg == TMO_LAST) begin
               timeout_next = 1'b1;
               tmo_next     = '0;
            end else begin
               tmo_next = tmo_reg + 32'd1;
            end
         end

         MEASURE: begin
            // Completion is checked first: it beats both a dropped enable
            // and a timeout expiring in the same cycle.
            if (completing) begin
               count_next = sat_inc(cyc_reg);
               valid_next = 1'b1;
               // The completing edge doubles as the next start edge.
               cyc_next   = '0;
               per_next   = '0;
               tmo_next   = '0;
               state_next = meas.enable ? MEASURE : IDLE;
            end else if (!meas.enable) begin
               cyc_next   = '0;
               per_next   = '0;
               tmo_next   = '0;
               state_next = IDLE;
            end else if (tmo_reg == TMO_LAST) begin
               timeout_next = 1'b1;
               cyc_next     = '0;
               per_next     = '0;
               tmo_next     = '0;
               state_next   = ARM;
            end else begin
               cyc_next = sat_inc(cyc_reg);
               tmo_next = tmo_reg + 32'd1;
               if (edge_pulse) begin
                  per_next = per_reg + 16'd1;
               end
            end
         end

         default: begin
            cyc_next   = '0;
            per_next   = '0;
            tmo_next   = '0;
            state_next = IDLE;
         end
      endcase
   end

   // busy follows the state being entered, so it mirrors state_reg exactly.
   assign busy_next = (state_next != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         cyc_reg     <= '0;
         per_reg     <= '0;
         tmo_reg     <= '0;
         count_reg   <= '0;
         valid_reg   <= 1'b0;
         timeout_reg <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cyc_reg     <= cyc_next;
         per_reg     <= per_next;
         tmo_reg     <= tmo_next;
         count_reg   <= count_next;
         valid_reg   <= valid_next;
         timeout_reg <= timeout_next;
         busy_reg    <= busy_next;
      end
   end

   assign meas.count_out   = count_reg;
   assign meas.count_valid = valid_reg;
   assign meas.timeout     = timeout_reg;
   assign meas.busy        = busy_reg;

endmodule

// File: tb/tb_osc_period_counter.sv
// Scoreboard bench for osc_period_counter. Two instances: one with
// N_PERIODS=4 / TIMEOUT_CYCLES=100 and one with N_PERIODS=1.
module tb_osc_period_counter;
   import osc_meas_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic osc4;
   logic osc1;

   osc_period_counter_if if4 ();
   osc_period_counter_if if1 ();

   osc_period_counter #(
      .N_PERIODS      (4),
      .TIMEOUT_CYCLES (32'd100),
      .SYNC_STAGES    (2)
   ) dut4 (
      .clk    (clk),
      .reset  (reset),
      .osc_in (osc4),
      .meas   (if4)
   );

   osc_period_counter #(
      .N_PERIODS      (1),
      .TIMEOUT_CYCLES (32'd1000),
      .SYNC_STAGES    (2)
   ) dut1 (
      .clk    (clk),
      .reset  (reset),
      .osc_in (osc1),
      .meas   (if1)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   longint q4[$];
   longint q1[$];
   longint cyc_num  = 0;
   longint last_v4  = -1;
   longint last_to4 = -1;
   int     n_to4    = 0;
   bit     allow_to4 = 1'b0;

   // Output monitor: samples 1 time unit after each rising clk edge.
   always begin
      @(posedge clk);
      #1;
      cyc_num++;
      if (if4.count_valid) begin
         if (q4.size() == 0) begin
            check_val("dut4_spurious_valid", if4.count_valid, 0);
         end else begin
            longint exp_v;
            exp_v = q4.pop_front();
            $display("txn dut4 count_out=%0d cycle=%0d", if4.count_out, cyc_num);
            check_val("dut4_count", if4.count_out, exp_v);
            if (last_v4 >= 0) check_val("dut4_valid_spacing", cyc_num - last_v4, 40);
            last_v4 = cyc_num;
         end
      end
      if (if4.timeout) begin
         if (!allow_to4) begin
            check_val("dut4_spurious_timeout", if4.timeout, 0);
         end else begin
            n_to4++;
            $display("txn dut4 timeout cycle=%0d", cyc_num);
            if (last_to4 >= 0) check_val("dut4_timeout_spacing", cyc_num - last_to4, 100);
            last_to4 = cyc_num;
         end
      end
      if (if1.count_valid) begin
         if (q1.size() == 0) begin
            check_val("dut1_spurious_valid", if1.count_valid, 0);
         end else begin
            longint exp_v;
            exp_v = q1.pop_front();
            $display("txn dut1 count_out=%0d cycle=%0d", if1.count_out, cyc_num);
            check_val("dut1_count", if1.count_out, exp_v);
         end
      end
      if (if1.timeout) check_val("dut1_spurious_timeout", if1.timeout, 0);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive4(input int hi, input int lo, input int n);
      for (int i = 0; i < n; i++) begin
         osc4 = 1'b1;
         tick(hi);
         osc4 = 1'b0;
         tick(lo);
      end
   endtask

   task automatic drive1(input int hi, input int lo);
      osc1 = 1'b1;
      tick(hi);
      osc1 = 1'b0;
      tick(lo);
   endtask

   initial begin
      int busy_low;
      int per_tab [9];
      per_tab = '{7, 9, 7, 9, 7, 9, 7, 9, 7};

      reset      = 1'b1;
      osc4       = 1'b0;
      osc1       = 1'b0;
      if4.enable = 1'b0;
      if1.enable = 1'b0;
      tick(3);

      // Reset values
      check_val("rst_count_out", if4.count_out, 0);
      check_val("rst_count_valid", if4.count_valid, 0);
      check_val("rst_timeout", if4.timeout, 0);
      check_val("rst_busy", if4.busy, 0);
      check_val("rst_dut1_busy", if1.busy, 0);
      reset = 1'b0;
      tick(2);

      // Continuous 10-cycle oscillator: start edge + 12 periods -> three 40s
      last_v4    = -1;
      if4.enable = 1'b1;
      repeat (3) q4.push_back(40);
      drive4(5, 5, 13);
      tick(2);
      if4.enable = 1'b0;
      tick(5);

      // Stuck-low oscillator: timeout every 100 cycles, busy held high
      allow_to4  = 1'b1;
      last_to4   = -1;
      busy_low   = 0;
      if4.enable = 1'b1;
      repeat (350) begin
         tick(1);
         if (!if4.busy) busy_low++;
      end
      check_val("timeout_busy_low_cycles", busy_low, 0);
      if4.enable = 1'b0;
      tick(3);
      allow_to4 = 1'b0;
      check_val("timeout_pulse_count", n_to4, 3);

      // Enable dropped after 2 of 4 periods, then a clean re-measurement
      last_v4    = -1;
      if4.enable = 1'b1;
      drive4(5, 5, 3);
      check_val("busy_before_drop", if4.busy, 1);
      if4.enable = 1'b0;
      tick(1);
      check_val("busy_after_drop", if4.busy, 0);
      tick(20);
      q4.push_back(40);
      if4.enable = 1'b1;
      drive4(5, 5, 5);
      tick(2);
      if4.enable = 1'b0;
      tick(5);

      // 25-cycle period: completing edge lands in the timeout-expiry cycle
      last_v4 = -1;
      q4.push_back(100);
      if4.enable = 1'b1;
      drive4(12, 13, 5);
      tick(2);
      if4.enable = 1'b0;
      tick(5);

      // Reset mid-MEASURE, then a fresh measurement
      last_v4    = -1;
      if4.enable = 1'b1;
      drive4(5, 5, 2);
      reset = 1'b1;
      tick(1);
      check_val("midrst_count_out", if4.count_out, 0);
      check_val("midrst_count_valid", if4.count_valid, 0);
      check_val("midrst_timeout", if4.timeout, 0);
      check_val("midrst_busy", if4.busy, 0);
      tick(2);
      reset = 1'b0;
      tick(3);
      q4.push_back(40);
      drive4(5, 5, 5);
      tick(2);
      if4.enable = 1'b0;
      tick(5);

      // N_PERIODS=1 with alternating 7/9-cycle periods
      if1.enable = 1'b1;
      for (int i = 0; i < 8; i++) q1.push_back(per_tab[i]);
      for (int i = 0; i < 9; i++) drive1(per_tab[i] / 2, per_tab[i] - per_tab[i] / 2);
      tick(2);
      if1.enable = 1'b0;
      tick(5);

      check_val("dut4_results_outstanding", q4.size(), 0);
      check_val("dut1_results_outstanding", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/osc_period_counter.md
# osc_period_counter

Measures the period of an asynchronous oscillator input by counting `clk` cycles across N_PERIODS oscillator periods. Produces one 32-bit count per measurement with a single-cycle valid pulse. Sits directly upstream of the averaging filter: `count_out`/`count_valid` drive its `data_in`/`data_valid`. Back-to-back measurements share boundary edges, so the output stream has no dead time while `enable` is high.

## Interface
- N_PERIODS, 16, oscillator periods per measurement (1 to 65535)
- TIMEOUT_CYCLES, 32'd50_000_000, `clk` cycles allowed per measurement before abort (≥ 2)
- SYNC_STAGES, 2, synchronizer flops on `osc_in` (≥ 2)
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- osc_in  input  1  asynchronous oscillator signal
- enable  input  1  level; high = measure continuously
- count_out  output  32  `clk` cycles spanned by the last N_PERIODS periods
- count_valid  output  1  one-cycle pulse; `count_out` is new
- timeout  output  1  one-cycle pulse; measurement aborted for lack of edges
- busy  output  1  high in ARM or MEASURE

## Operation
- Synchronize `osc_in` through SYNC_STAGES flops, then detect rising edges against one history flop. `edge` is a registered single-cycle pulse.
- States:
  - IDLE: counters cleared. Moves to ARM when `enable` is high.
  - ARM: waits for the first `edge`. On `edge`, clear `cyc_cnt` to 0, clear `per_cnt` to 0, go to MEASURE.
  - MEASURE: `cyc_cnt` += 1 every cycle. On `edge`, `per_cnt` += 1.
    - When the edge that makes `per_cnt` reach N_PERIODS arrives, register `count_out` = `cyc_cnt` + 1, including that cycle.
    - In the same cycle, restart: `cyc_cnt` ← 0 and `per_cnt` ← 0, staying in MEASURE. That edge is the start edge of the next measurement.
- Count definition: an oscillator of exactly P `clk` periods yields `count_out` = N_PERIODS·P.
- `cyc_cnt` is 32 bits and saturates at 0xFFFF_FFFF.
- A separate timeout counter clears on entry to ARM and at every measurement start.
  - If it reaches TIMEOUT_CYCLES in ARM or MEASURE: pulse `timeout`, go to ARM, discard the partial count.
  - `count_valid` is not asserted for an aborted measurement.
- `enable` low in any state: go to IDLE next cycle and discard any partial measurement. No `count_valid`, no `timeout`.
  - Exception: a completing edge in the same cycle still publishes its result.
- Simultaneous completing edge and timeout expiry in the same cycle: completion wins. Pulse `count_valid`, do not pulse `timeout`.
- `count_out` holds its value between pulses. It is never cleared except by reset.

## Timing
- Reset values: `count_out` = 0, `count_valid` = 0, `timeout` = 0, `busy` = 0. State is IDLE; all counters and synchronizer flops are 0.
- `osc_in` rising edge to `edge` pulse: SYNC_STAGES + 1 cycles.
- Completing `edge` cycle to `count_valid`: `count_valid` and the new `count_out` appear on the next cycle, for exactly 1 cycle.
- `busy` is registered: high the cycle after leaving IDLE, low the cycle after returning to IDLE.
- Minimum resolvable oscillator period: 2 `clk` cycles high-to-high (Nyquist). Faster inputs give undefined counts but must not hang the FSM.
- Reset asserted mid-measurement: all outputs return to reset values next cycle. No pulse is emitted.

## Structure
- Package `osc_meas_pkg`:
  - state enum IDLE/ARM/MEASURE (2-bit)
  - `COUNT_W` = 32
  - `CNT_SAT` = 32'hFFFF_FFFF
- Sub-module `sync_edge_detect`:
  - parameter SYNC_STAGES
  - ports `clk`, `reset`, `async_in`, `rise_pulse`
  - reusable for other asynchronous inputs.
- Top-level holds the FSM, `cyc_cnt`, `per_cnt` (16-bit), the timeout counter, and the output registers.

## Test plan
- N_PERIODS=4, `osc_in` period 10 `clk` (5 high / 5 low), `enable` held high → first `count_valid` carries 40. Every subsequent pulse carries 40, spaced exactly 40 cycles apart.
- N_PERIODS=1, period alternating 7 then 9 `clk` → `count_out` alternates 7, 9 with no missing samples.
- TIMEOUT_CYCLES=100, `osc_in` stuck low, `enable` high → `timeout` pulses every 100 cycles, `count_valid` never asserts, `busy` stays 1.
- `enable` dropped after 2 of 4 periods → no `count_valid`. `busy` falls after 1 cycle. Re-enable gives a clean 40 after a fresh ARM.
- Reset pulsed mid-MEASURE, then N_PERIODS=4 at 10-cycle period → outputs are 0/0/0/0 during reset, next result is 40. A completing edge landing in the timeout-expiry cycle yields `count_valid` only.
